// File: rtl/convergence_checker.sv
// convergence_checker
//   Sits between the divider (new means) and the controller. Receives the new centroids
//   of one iteration in index order, each paired with its previous value. It computes the
//   Manhattan distance between the two and compares it against a threshold. Each new
//   centroid is forwarded to the classification block. Once the last centroid has
//   drained, the block reports whether every centroid moved by no more than the threshold.
//
// Ports
//   clk                        clock, all state on posedge
//   rst                        asynchronous active-high reset
//   i_clr                      synchronous clear: drop any partial pass, return to idle
//   i_new_cent_valid           new/old data and index below are valid this cycle
//   i_new_cent_idx             index of the incoming centroid
//   i_new_cent_data            new mean, coordinate k at [k*CordWidth +: CordWidth]
//   i_old_cent_data            previous centroid with the same index
//   i_cnvrg_threshold          centroid converged iff distance <= threshold
//   o_cent_wr_en               one-hot, single-cycle write strobe to classification block
//   o_cent_wr_data             centroid being written
//   o_has_converged            all distances <= threshold (qualified by available)
//   o_converge_res_available   result valid, held until clear
//   o_seq_err                  sticky: out-of-order index, or valid after the pass ended

module convergence_checker #(
    parameter int unsigned CentroidNum = 8,
    parameter int unsigned Log2CentNum = 3,
    parameter int unsigned Dim         = 7,
    parameter int unsigned CordWidth   = 13,
    parameter int unsigned ManWidth    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_clr,
    input  logic                      i_new_cent_valid,
    input  logic [Log2CentNum-1:0]    i_new_cent_idx,
    input  logic [Dim*CordWidth-1:0]  i_new_cent_data,
    input  logic [Dim*CordWidth-1:0]  i_old_cent_data,
    input  logic [ManWidth-1:0]       i_cnvrg_threshold,
    output logic [CentroidNum-1:0]    o_cent_wr_en,
    output logic [Dim*CordWidth-1:0]  o_cent_wr_data,
    output logic                      o_has_converged,
    output logic                      o_converge_res_available,
    output logic                      o_seq_err
);

    localparam int unsigned DataW   = Dim * CordWidth;
    localparam int unsigned SumBase = CordWidth + $clog2(Dim) + 1;
    // Sum is kept wide enough never to wrap and at least one bit wider than the distance.
    localparam int unsigned SumW    = (SumBase > ManWidth) ? SumBase : ManWidth + 1;
    localparam logic [SumW-1:0] DistMax = {{(SumW - ManWidth){1'b0}}, {ManWidth{1'b1}}};

    typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic                   w_accept;
    logic                   w_err;
    logic                   w_is_last;
    logic [Log2CentNum:0]   r_exp_idx;

    // Stage 0: accepted sample
    logic                   r_s0_valid;
    logic                   r_s0_last;
    logic [Log2CentNum-1:0] r_s0_idx;
    logic [DataW-1:0]       r_s0_new;
    logic [DataW-1:0]       r_s0_old;

    // Stage 1: per-coordinate absolute differences
    logic                   r_s1_valid;
    logic                   r_s1_last;
    logic [Log2CentNum-1:0] r_s1_idx;
    logic [DataW-1:0]       r_s1_new;
    logic [DataW-1:0]       r_s1_diff;
    logic [DataW-1:0]       w_diff;

    // Stage 2: distance, write strobe, running verdict
    logic [SumW-1:0]        w_sum;
    logic [ManWidth-1:0]    w_dist;
    logic                   w_dist_ok;
    logic [CentroidNum-1:0] w_onehot;
    logic                   r_s2_last;
    logic                   r_all_ok;
    logic [CentroidNum-1:0] r_cent_wr_en;
    logic [DataW-1:0]       r_cent_wr_data;

    logic                   r_avail;
    logic                   r_has_conv;
    logic                   r_seq_err;

    assign w_is_last = (i_new_cent_idx == Log2CentNum'(CentroidNum - 1));

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_err        = 1'b0;
        if (i_clr) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_new_cent_valid) begin
                        if (i_new_cent_idx == '0) begin
                            w_accept     = 1'b1;
                            w_state_next = StCollect;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                end
                StCollect: begin
                    // After the last index is taken r_exp_idx == CentroidNum, which no
                    // index can match, so late valids are flagged as errors.
                    if (i_new_cent_valid) begin
                        if ({1'b0, i_new_cent_idx} == r_exp_idx) begin
                            w_accept = 1'b1;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                    if (r_s2_last) begin
                        w_state_next = StDone;
                    end
                end
                StDone: begin
                    if (i_new_cent_valid) begin
                        w_err = 1'b1;
                    end
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------ datapath
    for (genvar k = 0; k < Dim; k++) begin : g_diff
        logic [CordWidth-1:0] w_a;
        logic [CordWidth-1:0] w_b;
        assign w_a = r_s0_new[k*CordWidth +: CordWidth];
        assign w_b = r_s0_old[k*CordWidth +: CordWidth];
        assign w_diff[k*CordWidth +: CordWidth] = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < Dim; k++) begin
            w_sum = w_sum + SumW'(r_s1_diff[k*CordWidth +: CordWidth]);
        end
    end

    assign w_dist    = (w_sum > DistMax) ? {ManWidth{1'b1}} : w_sum[ManWidth-1:0];
    assign w_dist_ok = (w_dist <= i_cnvrg_threshold);
    assign w_onehot  = CentroidNum'(1) << r_s1_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exp_idx      <= '0;
            r_s0_valid     <= 1'b0;
            r_s0_last      <= 1'b0;
            r_s0_idx       <= '0;
            r_s0_new       <= '0;
            r_s0_old       <= '0;
            r_s1_valid     <= 1'b0;
            r_s1_last      <= 1'b0;
            r_s1_idx       <= '0;
            r_s1_new       <= '0;
            r_s1_diff      <= '0;
            r_s2_last      <= 1'b0;
            r_all_ok       <= 1'b0;
            r_cent_wr_en   <= '0;
            r_cent_wr_data <= '0;
            r_avail        <= 1'b0;
            r_has_conv     <= 1'b0;
            r_seq_err      <= 1'b0;
        end else if (i_clr) begin
            r_exp_idx      <= '0;
            r_s0_valid     <= 1'b0;
            r_s0_last      <= 1'b0;
            r_s1_valid     <= 1'b0;
            r_s1_last      <= 1'b0;
            r_s2_last      <= 1'b0;
            r_all_ok       <= 1'b0;
            r_cent_wr_en   <= '0;
            r_cent_wr_data <= '0;
            r_avail        <= 1'b0;
            r_has_conv     <= 1'b0;
            r_seq_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_exp_idx <= {1'b0, i_new_cent_idx} + (Log2CentNum + 1)'(1);
            end

            r_s0_valid <= w_accept;
            if (w_accept) begin
                r_s0_last <= w_is_last;
                r_s0_idx  <= i_new_cent_idx;
                r_s0_new  <= i_new_cent_data;
                r_s0_old  <= i_old_cent_data;
            end

            r_s1_valid <= r_s0_valid;
            if (r_s0_valid) begin
                r_s1_last <= r_s0_last;
                r_s1_idx  <= r_s0_idx;
                r_s1_new  <= r_s0_new;
                r_s1_diff <= w_diff;
            end

            r_cent_wr_en <= r_s1_valid ? w_onehot : '0;
            if (r_s1_valid) begin
                r_cent_wr_data <= r_s1_new;
            end
            r_s2_last <= r_s1_valid & r_s1_last;

            // A pass only starts from idle, so no earlier sample can still be in flight.
            if (w_accept && (r_state == StIdle)) begin
                r_all_ok <= 1'b1;
            end else if (r_s1_valid && !w_dist_ok) begin
                r_all_ok <= 1'b0;
            end

            if (r_s2_last) begin
                r_avail    <= 1'b1;
                r_has_conv <= r_all_ok;
            end

            if (w_err) begin
                r_seq_err <= 1'b1;
            end
        end
    end

    assign o_cent_wr_en             = r_cent_wr_en;
    assign o_cent_wr_data           = r_cent_wr_data;
    assign o_has_converged          = r_has_conv;
    assign o_converge_res_available = r_avail;
    assign o_seq_err                = r_seq_err;

endmodule

// File: tb/tb_convergence_checker.sv
module tb_convergence_checker;

    localparam int unsigned NC  = 8;
    localparam int unsigned LW  = 3;
    localparam int unsigned DIM = 7;
    localparam int unsigned CW  = 13;
    localparam int unsigned MW  = 16;
    localparam int unsigned DW  = DIM * CW;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          vld;
    logic [LW-1:0] idx;
    logic [DW-1:0] nd;
    logic [DW-1:0] od;
    logic [MW-1:0] thr;
    logic [NC-1:0] wr_en;
    logic [DW-1:0] wr_data;
    logic          conv;
    logic          avail;
    logic          serr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    convergence_checker dut (
        .clk                      (clk),
        .rst                      (rst),
        .i_clr                    (clr),
        .i_new_cent_valid         (vld),
        .i_new_cent_idx           (idx),
        .i_new_cent_data          (nd),
        .i_old_cent_data          (od),
        .i_cnvrg_threshold        (thr),
        .o_cent_wr_en             (wr_en),
        .o_cent_wr_data           (wr_data),
        .o_has_converged          (conv),
        .o_converge_res_available (avail),
        .o_seq_err                (serr)
    );

    typedef struct {
        logic          vld;
        logic [LW-1:0] idx;
        logic          acc;
        logic [NC-1:0] exp_en;
        logic [DW-1:0] exp_data;
        logic          exp_avail;
        logic          exp_conv;
        logic          exp_err;
    } row_t;

    row_t          tbl [64];
    int            n_rows;
    logic [DW-1:0] g_new [NC];
    logic [DW-1:0] g_old [NC];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mk_cent(input int i);
        logic [DW-1:0] v;
        v = '0;
        for (int k = 0; k < int'(DIM); k++) v[k*CW +: CW] = CW'(i * 300 + k * 37 + 5);
        return v;
    endfunction

    task automatic set_std();
        for (int i = 0; i < int'(NC); i++) begin
            g_new[i] = mk_cent(i);
            g_old[i] = mk_cent(i);
        end
    endtask

    task automatic add_row(input logic v, input int i, input logic a);
        tbl[n_rows].vld       = v;
        tbl[n_rows].idx       = LW'(i);
        tbl[n_rows].acc       = a;
        tbl[n_rows].exp_en    = '0;
        tbl[n_rows].exp_data  = '0;
        tbl[n_rows].exp_avail = 1'b0;
        tbl[n_rows].exp_conv  = 1'b0;
        tbl[n_rows].exp_err   = 1'b0;
        n_rows++;
    endtask

    // Write strobe appears two edges after acceptance; result three edges after the last.
    task automatic fill_expect(input logic c, input int err_row);
        int last;
        last = -1;
        for (int r = 0; r < n_rows; r++) if (tbl[r].acc) last = r;
        for (int r = 0; r < n_rows; r++) begin
            if (r >= 2) begin
                if (tbl[r-2].acc) begin
                    tbl[r].exp_en   = NC'(1) << tbl[r-2].idx;
                    tbl[r].exp_data = g_new[tbl[r-2].idx];
                end
            end
            tbl[r].exp_avail = (last >= 0) && (r >= last + 3);
            tbl[r].exp_conv  = tbl[r].exp_avail ? c : 1'b0;
            tbl[r].exp_err   = (err_row >= 0) && (r >= err_row);
        end
    endtask

    task automatic build_pass(input int gap, input logic c);
        n_rows = 0;
        for (int i = 0; i < int'(NC); i++) begin
            add_row(1'b1, i, 1'b1);
            for (int g = 0; g < gap; g++) add_row(1'b0, 0, 1'b0);
        end
        for (int g = 0; g < 4; g++) add_row(1'b0, 0, 1'b0);
        fill_expect(c, -1);
    endtask

    task automatic run_table(input string tag);
        for (int r = 0; r < n_rows; r++) begin
            vld = tbl[r].vld;
            idx = tbl[r].idx;
            nd  = g_new[tbl[r].idx];
            od  = g_old[tbl[r].idx];
            tick();
            vld = 1'b0;
            chk($sformatf("%s row%0d wr_en", tag, r), 128'(wr_en), 128'(tbl[r].exp_en));
            if (tbl[r].exp_en != '0)
                chk($sformatf("%s row%0d wr_data", tag, r), 128'(wr_data), 128'(tbl[r].exp_data));
            chk($sformatf("%s row%0d avail", tag, r), 128'(avail), 128'(tbl[r].exp_avail));
            chk($sformatf("%s row%0d conv", tag, r), 128'(conv), 128'(tbl[r].exp_conv));
            chk($sformatf("%s row%0d seq_err", tag, r), 128'(serr), 128'(tbl[r].exp_err));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " wr_en"}, 128'(wr_en), 128'(0));
        chk({tag, " wr_data"}, 128'(wr_data), 128'(0));
        chk({tag, " avail"}, 128'(avail), 128'(0));
        chk({tag, " conv"}, 128'(conv), 128'(0));
        chk({tag, " seq_err"}, 128'(serr), 128'(0));
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk_zero("clr");
    endtask

    task automatic send(input int i);
        vld = 1'b1;
        idx = LW'(i);
        nd  = g_new[i];
        od  = g_old[i];
        tick();
        vld = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        vld = 1'b0;
        idx = '0;
        nd  = '0;
        od  = '0;
        thr = '0;
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;

        // 1: identical centroids, zero threshold
        set_std();
        build_pass(0, 1'b1);
        run_table("t1");

        // 2: centroid 5 coord 3 moved by 4
        set_std();
        g_new[5][3*CW +: CW] = g_old[5][3*CW +: CW] + CW'(4);
        do_clr();
        thr = 16'd3;
        build_pass(0, 1'b0);
        run_table("t2_thr3");
        do_clr();
        thr = 16'd4;
        build_pass(0, 1'b1);
        run_table("t2_thr4");

        // 3: maximal distance 7*8191 = 57337, must not wrap
        for (int i = 0; i < int'(NC); i++) begin
            g_new[i] = '1;
            g_old[i] = '0;
        end
        do_clr();
        thr = 16'hFFFF;
        build_pass(0, 1'b1);
        run_table("t3_ffff");
        do_clr();
        thr = 16'd57336;
        build_pass(0, 1'b0);
        run_table("t3_57336");
        do_clr();
        thr = 16'd57337;
        build_pass(0, 1'b1);
        run_table("t3_57337");

        // 4: sequence 0,1,3 -> idx 3 dropped with error, then 2..7 completes
        set_std();
        thr = '0;
        do_clr();
        n_rows = 0;
        add_row(1'b1, 0, 1'b1);
        add_row(1'b1, 1, 1'b1);
        add_row(1'b1, 3, 1'b0);
        for (int i = 2; i < int'(NC); i++) add_row(1'b1, i, 1'b1);
        for (int g = 0; g < 4; g++) add_row(1'b0, 0, 1'b0);
        fill_expect(1'b1, 2);
        run_table("t4");

        // 5: clr together with valid idx 4
        do_clr();
        for (int i = 0; i < 4; i++) send(i);
        chk("t5 wr_en before clr", 128'(wr_en), 128'(8'h02));
        vld = 1'b1;
        idx = LW'(4);
        nd  = g_new[4];
        od  = g_old[4];
        clr = 1'b1;
        tick();
        vld = 1'b0;
        clr = 1'b0;
        chk_zero("t5 after clr");
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("t5 drain%0d wr_en", c), 128'(wr_en), 128'(0));
        end
        build_pass(0, 1'b1);
        run_table("t5_fresh");

        // 6: asynchronous reset mid-pass
        do_clr();
        for (int i = 0; i < 3; i++) send(i);
        chk("t6 wr_en before rst", 128'(wr_en), 128'(8'h01));
        #2;
        rst = 1'b1;
        #1;
        chk_zero("t6 async rst");
        tick();
        #3;
        rst = 1'b0;
        tick();
        build_pass(2, 1'b1);
        run_table("t6_gap2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
